// File: rtl/isa_shared_pkg.sv
// Shared ISA-level types for the core: memory access sizes,
// load sign-extension selects and the LSU sequencer states.
package isa_shared;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_access_type_e;

  typedef enum logic [2:0] {
    SX_NONE,
    SX_0700,
    SXU_0700,
    SX_1500,
    SXU_1500
  } sx_ops_e;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP,
    LSU_FAULT
  } lsu_state_e;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  // Map a load's size and signedness onto an extension select.
  function automatic sx_ops_e lsu_sx_sel(
    input logic [1:0] acc,
    input logic       uns
  );
    sx_ops_e sel;
    sel = SX_NONE;
    unique case (1'b1)
      (acc == MEM_BYTE): sel = uns ? SXU_0700 : SX_0700;
      (acc == MEM_HALF): sel = uns ? SXU_1500 : SX_1500;
      default:           sel = SX_NONE;
    endcase
    return sel;
  endfunction

  // Sizes that cannot be issued on the bus as-is.
  function automatic logic lsu_bad_access(
    input logic [1:0] acc,
    input logic [1:0] a
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (acc == MEM_BYTE): bad = 1'b0;
      (acc == MEM_HALF): bad = a[0];
      (acc == MEM_WORD): bad = (a != 2'b00);
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Lane steering for the LSU: byte enables, store-data replication
// and load-data shift/extension. Purely combinational.
//   access_i/unsigned_i/addr_i : size, signedness, low address bits
//   wdata_i/rdata_i            : raw store data / raw bus read word
//   be_o/wdata_repl_o          : bus byte enables / replicated data
//   rdata_ext_o                : aligned and extended load result
module lsu_data_align
  import isa_shared::*;
(
  input  logic [1:0]  access_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_repl_o,
  output logic [31:0] rdata_ext_o
);

  logic [31:0] shifted;
  sx_ops_e     sx;

  assign shifted = rdata_i >> {addr_i, 3'b000};
  assign sx      = lsu_sx_sel(access_i, unsigned_i);

  always_comb begin
    be_o         = 4'b0000;
    wdata_repl_o = 32'h0;
    unique case (1'b1)
      (access_i == MEM_BYTE): begin
        be_o         = 4'b0001 << addr_i;
        wdata_repl_o = {4{wdata_i[7:0]}};
      end
      (access_i == MEM_HALF): begin
        be_o         = 4'b0011 << addr_i;
        wdata_repl_o = {2{wdata_i[15:0]}};
      end
      (access_i == MEM_WORD): begin
        be_o         = 4'b1111;
        wdata_repl_o = wdata_i;
      end
      default: begin
        be_o         = 4'b0000;
        wdata_repl_o = 32'h0;
      end
    endcase
  end

  always_comb begin
    rdata_ext_o = shifted;
    unique case (sx)
      SX_0700:  rdata_ext_o = {{24{shifted[7]}}, shifted[7:0]};
      SXU_0700: rdata_ext_o = {24'h0, shifted[7:0]};
      SX_1500:  rdata_ext_o = {{16{shifted[15]}}, shifted[15:0]};
      SXU_1500: rdata_ext_o = {16'h0, shifted[15:0]};
      default:  rdata_ext_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute and the data-memory bus.
// Ports: lsu_* core handshake + op fields, done/fault/rdata result,
// busy_o, mem_* req/gnt/rvalid bus with word address and byte enables.
module lsu_mem_ctrl
  import isa_shared::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        is_store_i,
  input  logic [1:0]  access_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q;
  logic [1:0]        acc_q;
  logic              store_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              accept;
  logic              timeout;
  logic              in_req;
  logic [3:0]        be;
  logic [31:0]       wrepl;
  logic [31:0]       rext;
  logic [31:0]       rcap;

  assign accept  = (state_q == LSU_IDLE) && lsu_valid_i;
  assign timeout = (cnt_q == TO_LAST);
  assign in_req  = (state_q == LSU_REQ);
  // Stores complete with a zero result.
  assign rcap    = store_q ? 32'h0 : rext;

  lsu_data_align u_align (
    .access_i     (acc_q),
    .unsigned_i   (uns_q),
    .addr_i       (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .rdata_i      (mem_rdata_i),
    .be_o         (be),
    .wdata_repl_o (wrepl),
    .rdata_ext_o  (rext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (lsu_valid_i) begin
          cnt_d   = '0;
          rdata_d = 32'h0;
          state_d = lsu_bad_access(access_i, addr_i[1:0])
                    ? LSU_FAULT : LSU_REQ;
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt_i && mem_rvalid_i) begin
          rdata_d = rcap;
          state_d = LSU_RESP;
        end else if (timeout) begin
          state_d = LSU_FAULT;
        end else if (mem_gnt_i) begin
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the last allowed cycle still completes.
        if (mem_rvalid_i) begin
          rdata_d = rcap;
          state_d = LSU_RESP;
        end else if (timeout) begin
          state_d = LSU_FAULT;
        end
      end
      LSU_RESP:  state_d = LSU_IDLE;
      LSU_FAULT: state_d = LSU_IDLE;
      default:   state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Op fields are frozen at accept so the bus view stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= 32'h0;
      acc_q   <= 2'b00;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      addr_q  <= addr_i;
      acc_q   <= access_i;
      store_q <= is_store_i;
      uns_q   <= unsigned_i;
      wdata_q <= wdata_i;
    end
  end

  assign lsu_ready_o = (state_q == LSU_IDLE);
  assign busy_o      = (state_q != LSU_IDLE);
  assign done_o      = (state_q == LSU_RESP) || (state_q == LSU_FAULT);
  assign fault_o     = (state_q == LSU_FAULT);
  assign rdata_o     = (state_q == LSU_RESP) ? rdata_q : 32'h0;

  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && store_q;
  assign mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be_o    = in_req ? be : 4'b0000;
  assign mem_wdata_o = (in_req && store_q) ? wrepl : 32'h0;

endmodule
